enemy_wave: RTL and testbench
=============================

// Module: enemy_wave
// PURPOSE
// Parametrised formation of ROWS x COLS enemies sharing one 8x8 sprite. It replaces single-enemy instances in the game core.
// Tracks a per-enemy alive mask, marches the formation left/right with a step-down at each edge, and resolves player-bullet hits.
// Generates pixel colour for the VGA mixer and the wave-level status flags cleared and invaded.
// PARAMETERS
// ROWS        4     formation rows (1..8)
// COLS        8     formation columns (1..16)
// SCALE       3     sprite pixel magnification; sprite box = 8*SCALE square
// PITCH_LOG2  5     cell pitch = 2**PITCH_LOG2 px; must be >= 8*SCALE
// STEP_PX     2     horizontal march step, px
// DROP_PX     8     vertical step at an edge, px
// MOVE_DIV    4     frame_tick pulses per march step (>=1)
// X0, Y0      40,40 formation origin loaded at reset/start
// X_MAX       616   right limit for the formation's right edge
// INVADE_Y    440   formation bottom >= this -> invaded
// COLOR       24'hFF0000  sprite RGB
// PORTS
// clk         in   1   system clock
// reset       in   1   synchronous, active-high
// start       in   1   one-cycle pulse: reload origin, all alive, enter MARCH
// frame_tick  in   1   one-cycle pulse per video frame
// h_counter   in   10  current pixel x
// v_counter   in   10  current pixel y
// bullet_x    in   10  player bullet x
// bullet_y    in   10  player bullet y
// bullet_vld  in   1   bullet in flight
// R,G,B       out  8 each  pixel colour, registered, 1-cycle latency
// hit         out  1   one-cycle pulse on a kill
// alive_cnt   out  $clog2(ROWS*COLS+1)  enemies remaining
// cleared     out  1   level: all enemies dead
// invaded     out  1   level: formation reached INVADE_Y
// BEHAVIOUR
// Reset, as a decided fact: reset reset, synchronous, active-high; clock clk.
// - While reset: state=IDLE, pos=(X0,Y0), dir=right, alive=all-ones, div_cnt=0.
// - While reset: R/G/B=0, hit=0, cleared=0, invaded=0, alive_cnt=ROWS*COLS.
// FSM IDLE -> MARCH on start. MARCH -> CLEARED when alive==0. MARCH -> INVADED when pos_y + (ROWS-1)*pitch + 8*SCALE >= INVADE_Y.
// - CLEARED and INVADED are terminal until start or reset.
// - When both terminal conditions hold in the same cycle, CLEARED wins.
// - start in any state restarts the wave and overrides every other event in that cycle.
// March, in MARCH only: div_cnt counts frame_tick pulses. At MOVE_DIV it wraps to 0 and one step happens.
// - A step moves pos_x by STEP_PX in dir.
// - If the next right edge would exceed X_MAX, or the next pos_x would go below 0, pos_y += DROP_PX and dir flips instead; pos_x is unchanged.
// - Edge detection uses the full grid width, including dead columns.
// Hit, in MARCH only, when bullet_vld is set: dx=bullet_x-pos_x, dy=bullet_y-pos_y, both unsigned 10-bit.
// - Cell: col=dx>>PITCH_LOG2, row=dy>>PITCH_LOG2. Offset: ox=dx mod pitch, oy=dy mod pitch.
// - A kill requires col<COLS, row<ROWS, ox<8*SCALE, oy<8*SCALE, the cell alive, and no underflow (bullet >= pos).
// - On a kill: clear the alive bit, pulse hit for 1 cycle, decrement alive_cnt. At most one kill per cycle.
// - A dead cell never re-triggers. Hit is evaluated against pre-step pos when a step happens in the same cycle.
// - In IDLE, CLEARED and INVADED, hit is 0 and alive does not change.
// Render: the same cell/offset decode is applied to (h_counter, v_counter).
// - Sprite row = oy/SCALE, col = ox/SCALE. The lit pattern is the invader bitmap below.
// - Pixel = COLOR if the cell is alive and the bitmap bit is set, else 0. Render is also active in IDLE.
// - Bitmap rows, bit7=left: 3C 7E FF CF FF 24 5A A5.
// - Output is registered: R/G/B reflect the counters of the previous cycle.
// cleared=(state==CLEARED); invaded=(state==INVADED).
// STRUCTURE
// enemy_pkg: state encoding (IDLE, MARCH, CLEARED, INVADED) and the 8x8 sprite bitmap constant.
// Sub-module enemy_sprite_rom(row[2:0], col[2:0] -> bit); one instance, purely combinational.
// Division by SCALE is done through the ROM index logic; the pitch uses shifts only.
// TESTING
// 1. Reset, then start: alive_cnt=32, pos=(40,40); pixel (40+9,40) is FF0000 one cycle later; pixel (40,40) is 0.
// 2. MOVE_DIV=4: 4 frame_ticks -> pos_x=42. March to edge: next step gives pos_y=48, dir=left, pos_x unchanged.
// 3. Bullet at (40+32+5, 40+5) with bullet_vld: hit pulse, cell(0,1) dead, alive_cnt=31. Bullet held: no second hit.
// 4. Bullet in the cell gap (ox=28): no hit. Bullet left of pos_x (underflow): no hit.
// 5. Kill all 32: cleared=1 on the cycle after the last hit. Further ticks do not move the formation. start restores 32.
// 6. Drive drops until bottom >= 440: invaded=1. A kill and a step in the same cycle: the kill uses the old pos.

Source files
------------

// File: rtl/enemy_pkg.sv
// Shared types for the enemy formation: wave state encoding and the invader sprite.
package enemy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MARCH   = 2'd1,
    ST_CLEARED = 2'd2,
    ST_INVADED = 2'd3
  } state_t;

  // Row 0 is the top line; bit 7 of each byte is the leftmost pixel.
  localparam logic [7:0] SPRITE [8] = '{
    8'h3C, 8'h7E, 8'hFF, 8'hCF, 8'hFF, 8'h24, 8'h5A, 8'hA5
  };

endpackage

// File: rtl/enemy_sprite_rom.sv
// 8x8 invader bitmap lookup, purely combinational.
module enemy_sprite_rom
  import enemy_pkg::*;
(
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  output logic       o_bit
);

  logic [7:0] w_line;

  assign w_line = SPRITE[i_row];
  assign o_bit  = w_line[3'd7 - i_col];

endmodule

// File: rtl/enemy_wave.sv
// ROWS x COLS enemy formation: alive mask, left/right march with edge drop, bullet kills,
// and a registered pixel colour (1-cycle latency from h/v counters to R/G/B).
module enemy_wave
  import enemy_pkg::*;
#(
  parameter int          ROWS       = 4,
  parameter int          COLS       = 8,
  parameter int          SCALE      = 3,
  parameter int          PITCH_LOG2 = 5,
  parameter int          STEP_PX    = 2,
  parameter int          DROP_PX    = 8,
  parameter int          MOVE_DIV   = 4,
  parameter int          X0         = 40,
  parameter int          Y0         = 40,
  parameter int          X_MAX      = 616,
  parameter int          INVADE_Y   = 440,
  parameter logic [23:0] COLOR      = 24'hFF0000
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             frame_tick,
  input  logic [9:0]                       h_counter,
  input  logic [9:0]                       v_counter,
  input  logic [9:0]                       bullet_x,
  input  logic [9:0]                       bullet_y,
  input  logic                             bullet_vld,
  output logic [7:0]                       R,
  output logic [7:0]                       G,
  output logic [7:0]                       B,
  output logic                             hit,
  output logic [$clog2(ROWS*COLS+1)-1:0]   alive_cnt,
  output logic                             cleared,
  output logic                             invaded
);

  localparam int N      = ROWS * COLS;
  localparam int CW     = $clog2(N + 1);
  localparam int IW     = (N > 1) ? $clog2(N) : 1;
  localparam int DW     = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int PITCH  = 1 << PITCH_LOG2;
  localparam int BOX    = 8 * SCALE;
  localparam int GRID_W = (COLS - 1) * PITCH + BOX;
  localparam int GRID_H = (ROWS - 1) * PITCH + BOX;
  localparam logic [9:0] OFS_MASK = 10'(PITCH - 1);

  // Map a point onto the grid; true when it lands inside a sprite box (alive or not).
  function automatic logic in_cell(input logic [9:0] p_x, input logic [9:0] p_y,
                                   input logic [9:0] a_x, input logic [9:0] a_y,
                                   output logic [IW-1:0] idx);
    logic [9:0] dx, dy, col, row, ox, oy;
    dx  = a_x - p_x;
    dy  = a_y - p_y;
    col = dx >> PITCH_LOG2;
    row = dy >> PITCH_LOG2;
    ox  = dx & OFS_MASK;
    oy  = dy & OFS_MASK;
    idx = IW'(32'(row) * COLS + 32'(col));
    return (a_x >= p_x) && (a_y >= p_y) && (32'(col) < COLS) && (32'(row) < ROWS)
        && (32'(ox) < BOX) && (32'(oy) < BOX);
  endfunction

  function automatic logic [5:0] sprite_rc(input logic [9:0] p_x, input logic [9:0] p_y,
                                           input logic [9:0] a_x, input logic [9:0] a_y);
    logic [9:0] ox, oy;
    ox = (a_x - p_x) & OFS_MASK;
    oy = (a_y - p_y) & OFS_MASK;
    return {3'(32'(oy) / SCALE), 3'(32'(ox) / SCALE)};
  endfunction

  state_t          r_state,     w_state_nx;
  logic [9:0]      r_pos_x,     w_pos_x_nx;
  logic [9:0]      r_pos_y,     w_pos_y_nx;
  logic            r_dir_left,  w_dir_left_nx;
  logic [N-1:0]    r_alive,     w_alive_nx;
  logic [CW-1:0]   r_alive_cnt, w_alive_cnt_nx;
  logic [DW-1:0]   r_div_cnt,   w_div_nx;
  logic            r_hit,       w_hit_nx;
  logic [7:0]      r_r, r_g, r_b;

  logic            w_b_in, w_p_in, w_rom_bit, w_p_lit, w_at_edge, w_invade;
  logic [IW-1:0]   w_b_idx, w_p_idx;
  logic [5:0]      w_p_rc;

  always_comb begin
    w_b_idx = '0;
    w_p_idx = '0;
    w_b_in  = in_cell(r_pos_x, r_pos_y, bullet_x, bullet_y, w_b_idx);
    w_p_in  = in_cell(r_pos_x, r_pos_y, h_counter, v_counter, w_p_idx);
    w_p_rc  = sprite_rc(r_pos_x, r_pos_y, h_counter, v_counter);
  end

  enemy_sprite_rom u_rom (
    .i_row (w_p_rc[5:3]),
    .i_col (w_p_rc[2:0]),
    .o_bit (w_rom_bit)
  );

  assign w_p_lit = w_p_in && r_alive[w_p_idx] && w_rom_bit;

  // Edge test spans the whole grid, dead columns included, so the march width never shrinks.
  assign w_at_edge = r_dir_left ? (32'(r_pos_x) < STEP_PX)
                                : (32'(r_pos_x) + STEP_PX + GRID_W > X_MAX);
  assign w_invade  = (32'(r_pos_y) + GRID_H >= INVADE_Y);

  always_comb begin
    w_state_nx     = r_state;
    w_pos_x_nx     = r_pos_x;
    w_pos_y_nx     = r_pos_y;
    w_dir_left_nx  = r_dir_left;
    w_alive_nx     = r_alive;
    w_alive_cnt_nx = r_alive_cnt;
    w_div_nx       = r_div_cnt;
    w_hit_nx       = 1'b0;
    if (start) begin
      w_state_nx     = ST_MARCH;
      w_pos_x_nx     = 10'(X0);
      w_pos_y_nx     = 10'(Y0);
      w_dir_left_nx  = 1'b0;
      w_alive_nx     = '1;
      w_alive_cnt_nx = CW'(N);
      w_div_nx       = '0;
    end else if (r_state == ST_MARCH) begin
      if (r_alive == '0)
        w_state_nx = ST_CLEARED;
      else if (w_invade)
        w_state_nx = ST_INVADED;
      if (frame_tick) begin
        if (32'(r_div_cnt) == MOVE_DIV - 1) begin
          w_div_nx = '0;
          if (w_at_edge) begin
            w_pos_y_nx    = r_pos_y + 10'(DROP_PX);
            w_dir_left_nx = ~r_dir_left;
          end else if (r_dir_left) begin
            w_pos_x_nx = r_pos_x - 10'(STEP_PX);
          end else begin
            w_pos_x_nx = r_pos_x + 10'(STEP_PX);
          end
        end else begin
          w_div_nx = r_div_cnt + DW'(1);
        end
      end
      // Decoded against the pre-step position.
      if (bullet_vld && w_b_in && r_alive[w_b_idx]) begin
        w_alive_nx[w_b_idx] = 1'b0;
        w_hit_nx            = 1'b1;
        w_alive_cnt_nx      = r_alive_cnt - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pos_x     <= 10'(X0);
      r_pos_y     <= 10'(Y0);
      r_dir_left  <= 1'b0;
      r_alive     <= '1;
      r_alive_cnt <= CW'(N);
      r_div_cnt   <= '0;
      r_hit       <= 1'b0;
      r_r         <= '0;
      r_g         <= '0;
      r_b         <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_pos_x     <= w_pos_x_nx;
      r_pos_y     <= w_pos_y_nx;
      r_dir_left  <= w_dir_left_nx;
      r_alive     <= w_alive_nx;
      r_alive_cnt <= w_alive_cnt_nx;
      r_div_cnt   <= w_div_nx;
      r_hit       <= w_hit_nx;
      r_r         <= w_p_lit ? COLOR[23:16] : 8'h00;
      r_g         <= w_p_lit ? COLOR[15:8]  : 8'h00;
      r_b         <= w_p_lit ? COLOR[7:0]   : 8'h00;
    end
  end

  assign R         = r_r;
  assign G         = r_g;
  assign B         = r_b;
  assign hit       = r_hit;
  assign alive_cnt = r_alive_cnt;
  assign cleared   = (r_state == ST_CLEARED);
  assign invaded   = (r_state == ST_INVADED);

endmodule

// File: tb/tb_enemy_wave.sv
// Directed bench for enemy_wave with default parameters; pixel and hit expectations go through a queue.
module tb_enemy_wave;

  logic       clk = 1'b0;
  logic       reset, start, frame_tick, bullet_vld;
  logic [9:0] h_counter, v_counter, bullet_x, bullet_y;
  logic [7:0] R, G, B;
  logic       hit, cleared, invaded;
  logic [5:0] alive_cnt;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] exp_q[$];
  logic        model_alive [4][8];
  int          X, Y;

  always #5 clk = ~clk;

  enemy_wave dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .frame_tick (frame_tick),
    .h_counter  (h_counter),
    .v_counter  (v_counter),
    .bullet_x   (bullet_x),
    .bullet_y   (bullet_y),
    .bullet_vld (bullet_vld),
    .R          (R),
    .G          (G),
    .B          (B),
    .hit        (hit),
    .alive_cnt  (alive_cnt),
    .cleared    (cleared),
    .invaded    (invaded)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      cyc();
      frame_tick = 1'b0;
      cyc();
    end
  endtask

  task automatic probe(input string tag, input int x, input int y, input logic [23:0] exp);
    h_counter = 10'(x);
    v_counter = 10'(y);
    exp_q.push_back({8'h00, exp});
    cyc();
    check(tag, {8'h00, R, G, B}, exp_q.pop_front());
  endtask

  // Pins the formation origin using row 0 of column c (lit for ox 6..17, oy 0..2).
  task automatic probe_pos(input string tag, input int px, input int py, input int c);
    probe({tag, "_lit"},   px + c*32 + 6, py,     24'hFF0000);
    probe({tag, "_left"},  px + c*32 + 5, py,     24'h000000);
    probe({tag, "_above"}, px + c*32 + 9, py - 1, 24'h000000);
  endtask

  task automatic shot(input string tag, input int bx, input int by, input logic e);
    bullet_x   = 10'(bx);
    bullet_y   = 10'(by);
    bullet_vld = 1'b1;
    exp_q.push_back(32'(e));
    cyc();
    check(tag, 32'(hit), exp_q.pop_front());
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; frame_tick = 1'b0; bullet_vld = 1'b0;
    h_counter = '0; v_counter = '0; bullet_x = '0; bullet_y = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        model_alive[r][c] = 1'b1;
    h_counter = 10'd49; v_counter = 10'd40;
    repeat (3) cyc();
    check("rst_rgb",     {8'h00, R, G, B}, 32'h0);
    check("rst_hit",     32'(hit),       32'd0);
    check("rst_cleared", 32'(cleared),   32'd0);
    check("rst_invaded", 32'(invaded),   32'd0);
    check("rst_alive",   32'(alive_cnt), 32'd32);
    reset = 1'b0;
    probe("idle_render", 49, 40, 24'hFF0000);

    pulse_start();
    check("start_alive", 32'(alive_cnt), 32'd32);
    probe("start_lit",  49, 40, 24'hFF0000);
    probe("start_dark", 40, 40, 24'h000000);

    // March: step every 4 ticks, 164 steps to x=368, then drop and reverse.
    ticks(3);
    probe_pos("tick3", 40, 40, 0);
    ticks(1);
    probe_pos("step1", 42, 40, 0);
    ticks(163 * 4);
    probe_pos("right_limit", 368, 40, 0);
    ticks(4);
    probe_pos("drop", 368, 48, 0);
    ticks(4);
    probe_pos("left", 366, 48, 0);
    X = 366; Y = 48;

    shot("hit_c1", X + 37, Y + 5, 1'b1);
    model_alive[0][1] = 1'b0;
    shot("hit_held", X + 37, Y + 5, 1'b0);
    check("alive_31", 32'(alive_cnt), 32'd31);
    probe("dead_cell", X + 41, Y, 24'h000000);
    shot("gap_ox28", X + 28, Y + 5, 1'b0);
    shot("underflow", X - 1, Y + 5, 1'b0);
    bullet_vld = 1'b0;
    exp_q.push_back(32'd0);
    cyc();
    check("no_vld", 32'(hit), exp_q.pop_front());
    check("alive_still_31", 32'(alive_cnt), 32'd31);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) begin
        shot($sformatf("kill_r%0d_c%0d", r, c), X + c*32 + 5, Y + r*32 + 5, model_alive[r][c]);
        model_alive[r][c] = 1'b0;
      end
    check("cleared_at_last_hit", 32'(cleared), 32'd0);
    bullet_vld = 1'b0;
    cyc();
    check("cleared_after", 32'(cleared),   32'd1);
    check("alive_zero",    32'(alive_cnt), 32'd0);
    ticks(8);
    check("cleared_hold",  32'(cleared),   32'd1);
    check("no_invade_clr", 32'(invaded),   32'd0);

    pulse_start();
    check("restart_alive",   32'(alive_cnt), 32'd32);
    check("restart_cleared", 32'(cleared),   32'd0);

    // Kill on the step cycle: bullet at old x=40 underflows against the new x=42.
    ticks(3);
    frame_tick = 1'b1;
    shot("kill_with_step", 40, 43, 1'b1);
    frame_tick = 1'b0;
    bullet_vld = 1'b0;
    cyc();
    check("alive_after_ks", 32'(alive_cnt), 32'd31);
    probe_pos("after_ks", 42, 40, 1);

    // 35 drops bring bottom (y+120) to 440; odd drop count ends on the right edge.
    frame_tick = 1'b1;
    for (int i = 0; i < 40000 && !invaded; i++) cyc();
    frame_tick = 1'b0;
    check("invaded", 32'(invaded), 32'd1);
    probe_pos("invade_pos", 368, 320, 1);
    ticks(8);
    probe_pos("invade_frozen", 368, 320, 1);
    shot("no_hit_invaded", 368 + 37, 325, 1'b0);
    bullet_vld = 1'b0;
    check("alive_invaded", 32'(alive_cnt), 32'd31);
    check("not_cleared",   32'(cleared),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
